wb_periph_bridge: RTL and testbench
===================================

Name: wb_periph_bridge

Overview:
- Wishbone classic responder that gives the management SoC access to the AS2650 internal peripheral bus.
- Acts as the initiator on that bus, the same bus the CPU drives. It reaches gpios, timers, serial_ports and sid.
- Requests bus ownership from the CPU wrapper, runs exactly one peripheral byte cycle, then acks the Wishbone access.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone window base; bits [31:10] are compared.
- GNT_TIMEOUT, 16, cycles to wait for bus_gnt_i before aborting; range 1..255.

Ports:
- wb_clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable
- wbs_sel_i  in  4  byte selects; only bit 0 is used
- wbs_dat_i  in  32  write data; only [7:0] is used
- wbs_adr_i  in  32  address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- bus_req_o  out  1  bus ownership request to CPU wrapper
- bus_gnt_i  in  1  ownership granted; CPU has released bus_cyc
- bus_cyc  out  1  peripheral bus cycle strobe
- bus_addr  out  6  peripheral register address
- bus_data_out  out  8  peripheral write data
- bus_we_gpios, bus_we_timers, bus_we_serial_ports, bus_we_sid  out  1 each  per-peripheral write enables
- bus_in_gpios, bus_in_timers, bus_in_serial_ports, bus_in_sid  in  8 each  per-peripheral read data
- timeout_o  out  1  sticky grant-timeout flag

Behaviour:
- Reset (rst_n low, takes effect immediately): state IDLE, every output 0, wbs_dat_o = 0, timeout counter = 0.
- Address match: wbs_adr_i[31:10] == BASE_ADDR[31:10].
  - wbs_adr_i[9:8] selects the peripheral: 0 gpios, 1 timers, 2 serial_ports, 3 sid.
  - bus_addr = wbs_adr_i[7:2]; registers are word-spaced.
  - An unmatched access is ignored: no ack, no bus activity.
- FSM states: IDLE, REQ, ACCESS, CAPTURE, ACK.
- IDLE: when wbs_cyc_i & wbs_stb_i & match, latch address, peripheral select, we, sel[0] and dat[7:0]. Go to REQ, clear the timeout counter.
- REQ:
  - bus_req_o = 1.
  - If wbs_cyc_i = 0: go to IDLE and drop the request; no bus cycle is run.
  - Else if bus_gnt_i = 1: go to ACCESS.
  - Else increment the counter. When it reaches GNT_TIMEOUT: set timeout_o, load wbs_dat_o = 32'hFFFF_FFFF, go to ACK.
- ACCESS: exactly one cycle.
  - bus_cyc = 1, bus_addr and bus_data_out driven from the latches.
  - The selected bus_we_* = we & sel0; all other we lines stay 0.
  - A write with sel0 = 0 still runs the bus_cyc, with no we.
  - Next state: CAPTURE if read, ACK if write.
- CAPTURE: bus_cyc = 0. On the clock edge, wbs_dat_o = {24'h0, selected bus_in_*}, because peripherals present read data one cycle after bus_cyc. Go to ACK.
- ACK:
  - wbs_ack_o = 1 for exactly one cycle, then IDLE.
  - timeout_o is cleared here if the access did not time out.
  - bus_req_o stays 1 from REQ through ACK and is 0 in IDLE.
- wbs_dat_o holds its value until the next read completion or timeout; writes leave it unchanged.
- Latency with bus_gnt_i already high: strobe is sampled at edge 0. Ack is visible in cycle 3 (write) or cycle 4 (read).
- No retrigger on the ack cycle: IDLE is entered after ACK, and the master has dropped the strobe by then.
- Simultaneous events:
  - bus_gnt_i rising on the same edge the counter hits GNT_TIMEOUT: grant wins, so the access proceeds and there is no timeout.
  - Grant dropping after ACCESS has begun is ignored; the cycle completes.
- A new request while in a non-IDLE state is not accepted until IDLE.

Test Plan:
- Write, gnt tied high: adr 0x3000_0108, dat 0x5A, sel 0x1.
  - bus_cyc pulses once, with bus_addr = 2, bus_data_out = 0x5A, bus_we_timers = 1 and all other we lines 0.
  - Ack 3 cycles after the strobe.
- Read: adr 0x3000_030C, bus_in_sid = 0xC3 → bus_addr = 3, no we; wbs_dat_o = 0x0000_00C3 with ack 4 cycles after the strobe.
- Grant delay: gnt held low 5 cycles, then high → bus_req_o stays high throughout; access completes normally; timeout_o = 0.
- Timeout: gnt never asserted.
  - Ack arrives after 16 REQ cycles with wbs_dat_o = 0xFFFF_FFFF, timeout_o = 1, and no bus_cyc.
  - A subsequent successful access clears timeout_o.
- Abort and window: wbs_cyc_i dropped while in REQ → IDLE, no bus_cyc, no ack. Adr 0x2000_0000 → nothing happens.
- Async reset: rst_n pulsed low during ACCESS → bus_cyc, bus_req_o and wbs_ack_o are 0 immediately; FSM is in IDLE after release.

Source files
------------

// File: rtl/wb_periph_bridge.sv
// ---------------------------------------------------------------------------
// wb_periph_bridge
// Wishbone classic responder that lets the management SoC reach the AS2650
// internal peripheral bus (gpios, timers, serial_ports, sid). Each Wishbone
// access requests bus ownership from the CPU wrapper, runs one byte-wide
// peripheral cycle and then acks the Wishbone access.
//
// Ports
//   wb_clk_i, rst_n        clock, asynchronous active-low reset
//   wbs_*                  Wishbone classic responder (only sel[0], dat[7:0] used)
//   bus_req_o / bus_gnt_i  ownership handshake with the CPU wrapper
//   bus_cyc, bus_addr,     peripheral bus initiator side
//   bus_data_out, bus_we_* (one write enable per peripheral)
//   bus_in_*               per-peripheral read data, valid one cycle after bus_cyc
//   timeout_o              sticky flag: last access gave up waiting for grant
// ---------------------------------------------------------------------------
module wb_periph_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        bus_cyc,
  output logic [5:0]  bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_we_gpios,
  output logic        bus_we_timers,
  output logic        bus_we_serial_ports,
  output logic        bus_we_sid,
  input  logic [7:0]  bus_in_gpios,
  input  logic [7:0]  bus_in_timers,
  input  logic [7:0]  bus_in_serial_ports,
  input  logic [7:0]  bus_in_sid,
  output logic        timeout_o
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NPER   = 4;
  localparam int unsigned RADR_W = 6;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACCESS,
    S_CAPTURE,
    S_ACK
  } state_t;

  // Wishbone request latched on acceptance
  typedef struct packed {
    logic [RADR_W-1:0] addr;
    logic [1:0]        per;
    logic              we;
    logic              sel0;
    logic [BYTE_W-1:0] dat;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ack_d;
  logic              breq_d;
  logic              cyc_d;
  logic              tmo_d;
  logic [RADR_W-1:0] addr_d;
  logic [BYTE_W-1:0] wdat_d;
  logic [WORD_W-1:0] rdat_d;
  logic [NPER-1:0]   we_d, we_q;

  logic              hit_c;
  logic [BYTE_W-1:0] rd_sel_c;
  logic              unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

  // Window decode on the upper address bits
  assign hit_c = (wbs_adr_i[31:10] == BASE_ADDR[31:10]);

  // Read-data mux for the latched peripheral
  always_comb begin
    rd_sel_c = '0;
    unique case (req_q.per)
      2'd0: rd_sel_c = bus_in_gpios;
      2'd1: rd_sel_c = bus_in_timers;
      2'd2: rd_sel_c = bus_in_serial_ports;
      2'd3: rd_sel_c = bus_in_sid;
      default: rd_sel_c = '0;
    endcase
  end

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdat_d  = wbs_dat_o;
    tmo_d   = timeout_o;
    ack_d   = 1'b0;
    breq_d  = 1'b0;
    cyc_d   = 1'b0;
    addr_d  = '0;
    wdat_d  = '0;
    we_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && hit_c) begin
          req_d.addr = wbs_adr_i[7:2];
          req_d.per  = wbs_adr_i[9:8];
          req_d.we   = wbs_we_i;
          req_d.sel0 = wbs_sel_i[0];
          req_d.dat  = wbs_dat_i[7:0];
          cnt_d      = '0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        // Abort beats grant; grant beats the timeout on the same edge
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (bus_gnt_i) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(GNT_TIMEOUT)) begin
            tmo_d   = 1'b1;
            rdat_d  = '1;
            state_d = S_ACK;
          end
        end
      end

      S_ACCESS: begin
        if (req_q.we) begin
          tmo_d   = 1'b0;
          state_d = S_ACK;
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        // Peripheral read data is valid in the cycle after bus_cyc
        rdat_d  = {(WORD_W-BYTE_W)'(0), rd_sel_c};
        tmo_d   = 1'b0;
        state_d = S_ACK;
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered and follow the state being entered
    unique case (state_d)
      S_REQ, S_CAPTURE: begin
        breq_d = 1'b1;
      end
      S_ACCESS: begin
        breq_d           = 1'b1;
        cyc_d            = 1'b1;
        addr_d           = req_d.addr;
        wdat_d           = req_d.dat;
        we_d[req_d.per]  = req_d.we & req_d.sel0;
      end
      S_ACK: begin
        breq_d = 1'b1;
        ack_d  = 1'b1;
      end
      default: begin
        breq_d = 1'b0;
      end
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      cnt_q        <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      bus_req_o    <= 1'b0;
      bus_cyc      <= 1'b0;
      bus_addr     <= '0;
      bus_data_out <= '0;
      we_q         <= '0;
      timeout_o    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cnt_q        <= cnt_d;
      wbs_ack_o    <= ack_d;
      wbs_dat_o    <= rdat_d;
      bus_req_o    <= breq_d;
      bus_cyc      <= cyc_d;
      bus_addr     <= addr_d;
      bus_data_out <= wdat_d;
      we_q         <= we_d;
      timeout_o    <= tmo_d;
    end
  end

  assign bus_we_gpios        = we_q[0];
  assign bus_we_timers       = we_q[1];
  assign bus_we_serial_ports = we_q[2];
  assign bus_we_sid          = we_q[3];

endmodule

// File: tb/tb_wb_periph_bridge.sv
// ---------------------------------------------------------------------------
// tb_wb_periph_bridge
// Self-checking bench for wb_periph_bridge. A peripheral model answers the
// bus (read data one cycle after bus_cyc) and logs every bus cycle; a
// register-array scoreboard plus latency rules give the expected results.
// Latency k is counted in clock edges after the edge that samples the strobe.
// ---------------------------------------------------------------------------
module tb_wb_periph_bridge;

  localparam int unsigned TMO = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        bus_req_o, bus_gnt_i = 1'b0, bus_cyc;
  logic [5:0]  bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_we_gpios, bus_we_timers, bus_we_serial_ports, bus_we_sid;
  logic [7:0]  bus_in_gpios = '0, bus_in_timers = '0, bus_in_serial_ports = '0, bus_in_sid = '0;
  logic        timeout_o;

  wb_periph_bridge #(.BASE_ADDR(BASE), .GNT_TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .rst_n(rst_n),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
    .bus_cyc(bus_cyc), .bus_addr(bus_addr), .bus_data_out(bus_data_out),
    .bus_we_gpios(bus_we_gpios), .bus_we_timers(bus_we_timers),
    .bus_we_serial_ports(bus_we_serial_ports), .bus_we_sid(bus_we_sid),
    .bus_in_gpios(bus_in_gpios), .bus_in_timers(bus_in_timers),
    .bus_in_serial_ports(bus_in_serial_ports), .bus_in_sid(bus_in_sid),
    .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc_count = 0;
  int          stray_we = 0;
  logic [5:0]  last_addr = '0;
  logic [7:0]  last_dat = '0;
  logic [3:0]  last_we = '0;
  logic [7:0]  periph_mem [4][64];
  logic [7:0]  ref_mem [4][64];
  logic [31:0] exp_dat = '0;

  // Peripheral model: logs bus cycles, applies writes, returns read data next cycle
  always @(posedge wb_clk_i) begin : periph_model
    logic       c;
    logic [5:0] a;
    logic [3:0] w;
    logic [7:0] d;
    c = bus_cyc;
    a = bus_addr;
    d = bus_data_out;
    w = {bus_we_sid, bus_we_serial_ports, bus_we_timers, bus_we_gpios};
    if (c) begin
      cyc_count++;
      last_addr = a;
      last_dat  = d;
      last_we   = w;
      for (int p = 0; p < 4; p++) if (w[p]) periph_mem[p][a] = d;
    end else if (w != 4'b0) begin
      stray_we++;
    end
    #1;
    if (c) begin
      bus_in_gpios        = periph_mem[0][a];
      bus_in_timers       = periph_mem[1][a];
      bus_in_serial_ports = periph_mem[2][a];
      bus_in_sid          = periph_mem[3][a];
    end else begin
      bus_in_gpios        = 8'($urandom);
      bus_in_timers       = 8'($urandom);
      bus_in_serial_ports = 8'($urandom);
      bus_in_sid          = 8'($urandom);
    end
  end

  // One Wishbone access; grant is held low for the first d REQ cycles
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int d,
                           output bit got_ack, output int ack_k, output logic [31:0] rdata,
                           output logic tmo, output bit req_gap);
    got_ack = 1'b0; ack_k = -1; rdata = '0; tmo = 1'b0; req_gap = 1'b0;
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; bus_gnt_i = (d == 0);
    for (int k = 0; k < 40 && !got_ack; k++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got_ack = 1'b1; ack_k = k; rdata = wbs_dat_o; tmo = timeout_o;
      end else if (!bus_req_o) begin
        req_gap = 1'b1;
      end
      bus_gnt_i = (k >= d);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; bus_gnt_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({wbs_ack_o, wbs_dat_o, bus_req_o, bus_cyc, bus_addr, bus_data_out, bus_we_gpios,
         bus_we_timers, bus_we_serial_ports, bus_we_sid, timeout_o} !== '0) begin
      n_err++; $display("FAIL reset_outputs: ack=%b dat=%h req=%b cyc=%b tmo=%b, want all 0",
                        wbs_ack_o, wbs_dat_o, bus_req_o, bus_cyc, timeout_o);
    end
    #5 rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    n_cmp++;
    if ({wbs_ack_o, bus_req_o, bus_cyc} !== 3'b000) begin
      n_err++; $display("FAIL idle_after_reset: ack=%b req=%b cyc=%b, want 000", wbs_ack_o, bus_req_o, bus_cyc);
    end
  endtask

  task automatic test_write();
    bit g, gap; int k; logic [31:0] rd; logic t; int c0;
    c0 = cyc_count;
    wb_access(32'h3000_0108, 1'b1, 4'h1, 32'h0000_005A, 0, g, k, rd, t, gap);
    ref_mem[1][2] = 8'h5A;
    n_cmp++; if (!g || k != 2) begin n_err++; $display("FAIL write_latency: got_ack=%0d k=%0d, want 1/2", g, k); end
    n_cmp++; if (cyc_count - c0 != 1) begin n_err++; $display("FAIL write_cyc_pulses: %0d, want 1", cyc_count - c0); end
    n_cmp++; if (last_addr !== 6'd2 || last_dat !== 8'h5A) begin n_err++; $display("FAIL write_addr_data: addr=%0d dat=%h, want 2/5a", last_addr, last_dat); end
    n_cmp++; if (last_we !== 4'b0010) begin n_err++; $display("FAIL write_we_lines: %b, want 0010", last_we); end
    n_cmp++; if (rd !== exp_dat || t !== 1'b0) begin n_err++; $display("FAIL write_dat_hold: dat=%h tmo=%b, want %h/0", rd, t, exp_dat); end
    n_cmp++; if (wbs_ack_o !== 1'b0 || bus_req_o !== 1'b0) begin n_err++; $display("FAIL write_after_ack: ack=%b req=%b, want 0/0", wbs_ack_o, bus_req_o); end
  endtask

  task automatic test_read();
    bit g, gap; int k; logic [31:0] rd; logic t; int c0;
    periph_mem[3][3] = 8'hC3; ref_mem[3][3] = 8'hC3;
    c0 = cyc_count;
    wb_access(32'h3000_030C, 1'b0, 4'h1, 32'h0, 0, g, k, rd, t, gap);
    exp_dat = {24'h0, ref_mem[3][3]};
    n_cmp++; if (!g || k != 3) begin n_err++; $display("FAIL read_latency: got_ack=%0d k=%0d, want 1/3", g, k); end
    n_cmp++; if (rd !== exp_dat) begin n_err++; $display("FAIL read_data: %h, want %h", rd, exp_dat); end
    n_cmp++; if (cyc_count - c0 != 1 || last_addr !== 6'd3 || last_we !== 4'b0) begin
      n_err++; $display("FAIL read_bus: pulses=%0d addr=%0d we=%b, want 1/3/0000", cyc_count - c0, last_addr, last_we); end
    n_cmp++; if (wbs_dat_o !== exp_dat) begin n_err++; $display("FAIL read_dat_hold: %h, want %h", wbs_dat_o, exp_dat); end
  endtask

  task automatic test_grant_delay();
    bit g, gap; int k; logic [31:0] rd; logic t;
    wb_access(32'h3000_001C, 1'b1, 4'h1, 32'h0000_0081, 5, g, k, rd, t, gap);
    ref_mem[0][7] = 8'h81;
    n_cmp++; if (!g || k != 7) begin n_err++; $display("FAIL gdelay_latency: got_ack=%0d k=%0d, want 1/7", g, k); end
    n_cmp++; if (gap) begin n_err++; $display("FAIL gdelay_req_held: bus_req_o dropped=1, want 0"); end
    n_cmp++; if (t !== 1'b0 || last_we !== 4'b0001) begin n_err++; $display("FAIL gdelay_result: tmo=%b we=%b, want 0/0001", t, last_we); end
    wb_access(32'h3000_001C, 1'b0, 4'h1, 32'h0, 2, g, k, rd, t, gap);
    exp_dat = {24'h0, ref_mem[0][7]};
    n_cmp++; if (!g || k != 5 || rd !== exp_dat) begin n_err++; $display("FAIL gdelay_readback: k=%0d dat=%h, want 5/%h", k, rd, exp_dat); end
  endtask

  task automatic test_timeout();
    bit g, gap; int k; logic [31:0] rd; logic t; int c0;
    c0 = cyc_count;
    wb_access(32'h3000_0214, 1'b0, 4'h1, 32'h0, 1000, g, k, rd, t, gap);
    exp_dat = 32'hFFFF_FFFF;
    n_cmp++; if (!g || k != TMO) begin n_err++; $display("FAIL tmo_latency: got_ack=%0d k=%0d, want 1/%0d", g, k, TMO); end
    n_cmp++; if (rd !== exp_dat || t !== 1'b1) begin n_err++; $display("FAIL tmo_result: dat=%h tmo=%b, want ffffffff/1", rd, t); end
    n_cmp++; if (cyc_count != c0) begin n_err++; $display("FAIL tmo_no_cyc: pulses=%0d, want 0", cyc_count - c0); end
    // Grant arriving on the edge the counter would expire wins
    wb_access(32'h3000_0228, 1'b0, 4'h1, 32'h0, TMO - 1, g, k, rd, t, gap);
    exp_dat = {24'h0, ref_mem[2][10]};
    n_cmp++; if (!g || k != TMO + 2 || rd !== exp_dat || t !== 1'b0) begin
      n_err++; $display("FAIL grant_wins: k=%0d dat=%h tmo=%b, want %0d/%h/0", k, rd, t, TMO + 2, exp_dat); end
    c0 = cyc_count;
    wb_access(32'h3000_0228, 1'b1, 4'h1, 32'h0000_0033, TMO, g, k, rd, t, gap);
    exp_dat = 32'hFFFF_FFFF;
    n_cmp++; if (!g || k != TMO || t !== 1'b1 || rd !== exp_dat || cyc_count != c0) begin
      n_err++; $display("FAIL tmo_boundary: k=%0d tmo=%b dat=%h pulses=%0d, want %0d/1/ffffffff/0", k, t, rd, cyc_count - c0, TMO); end
    wb_access(32'h3000_0000, 1'b1, 4'h1, 32'h0000_0011, 0, g, k, rd, t, gap);
    ref_mem[0][0] = 8'h11;
    n_cmp++; if (!g || t !== 1'b0 || rd !== exp_dat) begin n_err++; $display("FAIL tmo_clear: tmo=%b dat=%h, want 0/%h", t, rd, exp_dat); end
  endtask

  task automatic test_abort();
    int c0; int acks; bit req_seen;
    c0 = cyc_count; acks = 0;
    wbs_adr_i = 32'h3000_0104; wbs_we_i = 1'b1; wbs_sel_i = 4'h1; wbs_dat_i = 32'h77;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; bus_gnt_i = 1'b0;
    repeat (4) begin @(posedge wb_clk_i); #1; end
    req_seen = bus_req_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (25) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
      bus_gnt_i = 1'b1;
    end
    bus_gnt_i = 1'b0;
    n_cmp++; if (!req_seen) begin n_err++; $display("FAIL abort_req_before: req=0, want 1"); end
    n_cmp++; if (acks != 0 || cyc_count != c0 || bus_req_o !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: acks=%0d pulses=%0d req=%b, want 0/0/0", acks, cyc_count - c0, bus_req_o); end
  endtask

  task automatic test_window();
    int c0; int busy;
    c0 = cyc_count; busy = 0;
    wbs_adr_i = 32'h2000_0000; wbs_we_i = 1'b1; wbs_sel_i = 4'h1; wbs_dat_i = 32'h99;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; bus_gnt_i = 1'b1;
    repeat (20) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o || bus_req_o) busy++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; bus_gnt_i = 1'b0;
    n_cmp++; if (busy != 0 || cyc_count != c0) begin n_err++; $display("FAIL window_ignore: busy=%0d pulses=%0d, want 0/0", busy, cyc_count - c0); end
  endtask

  task automatic test_sel0_zero();
    bit g, gap; int k; logic [31:0] rd; logic t; int c0;
    c0 = cyc_count;
    wb_access(32'h3000_0124, 1'b1, 4'hE, 32'h0000_00AB, 0, g, k, rd, t, gap);
    n_cmp++; if (!g || k != 2 || cyc_count - c0 != 1 || last_we !== 4'b0) begin
      n_err++; $display("FAIL sel0_zero: k=%0d pulses=%0d we=%b, want 2/1/0000", k, cyc_count - c0, last_we); end
    wb_access(32'h3000_0124, 1'b0, 4'h1, 32'h0, 0, g, k, rd, t, gap);
    exp_dat = {24'h0, ref_mem[1][9]};
    n_cmp++; if (rd !== exp_dat) begin n_err++; $display("FAIL sel0_readback: %h, want %h", rd, exp_dat); end
  endtask

  task automatic test_random();
    bit g, gap; int k; logic [31:0] rd; logic t; int c0;
    int p, r, d, lat; logic we; logic [3:0] sel; logic [31:0] dat, adr; bit tmo_exp;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 3); r = $urandom_range(0, 63);
      we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15)); dat = $urandom;
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3);
      adr = BASE | (32'(p) << 8) | (32'(r) << 2) | 32'($urandom_range(0, 3));
      tmo_exp = (d >= TMO);
      lat = tmo_exp ? TMO : d + (we ? 2 : 3);
      c0 = cyc_count;
      wb_access(adr, we, sel, dat, d, g, k, rd, t, gap);
      if (tmo_exp) exp_dat = 32'hFFFF_FFFF;
      else if (!we) exp_dat = {24'h0, ref_mem[p][r]};
      else if (sel[0]) ref_mem[p][r] = dat[7:0];
      n_cmp++; if (!g || k != lat || gap) begin n_err++; $display("FAIL rnd%0d_latency: ack=%0d k=%0d gap=%0d, want 1/%0d/0", i, g, k, gap, lat); end
      n_cmp++; if (rd !== exp_dat || t !== tmo_exp) begin n_err++; $display("FAIL rnd%0d_result: dat=%h tmo=%b, want %h/%b", i, rd, t, exp_dat, tmo_exp); end
      n_cmp++;
      if (tmo_exp) begin
        if (cyc_count != c0) begin n_err++; $display("FAIL rnd%0d_bus: pulses=%0d, want 0", i, cyc_count - c0); end
      end else if (cyc_count - c0 != 1 || last_addr !== 6'(r) || last_we !== ((we && sel[0]) ? 4'(1 << p) : 4'b0)
                   || (we && last_dat !== dat[7:0])) begin
        n_err++; $display("FAIL rnd%0d_bus: pulses=%0d addr=%0d we=%b dat=%h, want 1/%0d/%b/%h", i, cyc_count - c0,
                          last_addr, last_we, last_dat, r, (we && sel[0]) ? 4'(1 << p) : 4'b0, dat[7:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit g, gap; int k; logic [31:0] rd; logic t; int quiet;
    wbs_adr_i = 32'h3000_0314; wbs_we_i = 1'b0; wbs_sel_i = 4'h1; wbs_dat_i = '0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; bus_gnt_i = 1'b1;
    @(posedge wb_clk_i); #1;
    @(posedge wb_clk_i); #1;
    n_cmp++; if (bus_cyc !== 1'b1) begin n_err++; $display("FAIL arst_in_access: cyc=%b, want 1", bus_cyc); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus_cyc, bus_req_o, wbs_ack_o, wbs_dat_o} !== '0) begin
      n_err++; $display("FAIL arst_immediate: cyc=%b req=%b ack=%b dat=%h, want 0/0/0/0", bus_cyc, bus_req_o, wbs_ack_o, wbs_dat_o); end
    exp_dat = '0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; bus_gnt_i = 1'b0;
    #3 rst_n = 1'b1;
    quiet = 0;
    repeat (3) begin @(posedge wb_clk_i); #1; if (bus_req_o || wbs_ack_o || bus_cyc) quiet++; end
    n_cmp++; if (quiet != 0) begin n_err++; $display("FAIL arst_idle: active cycles=%0d, want 0", quiet); end
    wb_access(32'h3000_0314, 1'b0, 4'h1, 32'h0, 0, g, k, rd, t, gap);
    exp_dat = {24'h0, ref_mem[3][5]};
    n_cmp++; if (!g || k != 3 || rd !== exp_dat) begin n_err++; $display("FAIL arst_recover: k=%0d dat=%h, want 3/%h", k, rd, exp_dat); end
  endtask

  initial begin
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 64; a++) begin
        ref_mem[p][a]    = 8'($urandom);
        periph_mem[p][a] = ref_mem[p][a];
      end
    test_reset();
    test_write();
    test_read();
    test_grant_delay();
    test_timeout();
    test_abort();
    test_window();
    test_sel0_zero();
    test_random();
    test_async_reset();
    n_cmp++; if (stray_we != 0) begin n_err++; $display("FAIL stray_we: %0d we pulses outside bus_cyc, want 0", stray_we); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
